// File: rtl/chacha20_pkg.sv
// Shared types, constants and index tables for the iterative ChaCha20 block controller.
package chacha20_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] state_t;
    typedef logic [3:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    // Row q lists the (a,b,c,d) word indices fed to quarter-round instance q.
    localparam idx_t COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam idx_t DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    function automatic word_t rotl(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic state_t init_state(input logic [255:0] key,
                                          input logic [95:0]  nonce,
                                          input word_t        counter);
        state_t s;
        s[0] = SIGMA0;
        s[1] = SIGMA1;
        s[2] = SIGMA2;
        s[3] = SIGMA3;
        for (int i = 0; i < 8; i++) s[4 + i] = key[32*i +: 32];
        s[12] = counter;
        for (int i = 0; i < 3; i++) s[13 + i] = nonce[32*i +: 32];
        return s;
    endfunction

endpackage

// File: rtl/chacha20_qr.sv
// ChaCha quarter-round: purely combinational add/xor/rotate network.
module chacha20_qr
    import chacha20_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t na,
    output word_t nb,
    output word_t nc,
    output word_t nd
);

    word_t a1, b1, c1, d1;

    assign a1 = a + b;
    assign d1 = rotl(d ^ a1, 16);
    assign c1 = c + d1;
    assign b1 = rotl(b ^ c1, 12);
    assign na = a1 + b1;
    assign nd = rotl(d1 ^ na, 8);
    assign nc = c1 + nd;
    assign nb = rotl(b1 ^ nc, 7);

endmodule

// File: rtl/chacha20_round_sel.sv
// Routes working-state words to the four quarter-rounds and scatters their results back,
// choosing column or diagonal grouping from the round parity.
module chacha20_round_sel
    import chacha20_pkg::*;
(
    input  state_t      work_st,
    input  logic        diag,
    input  word_t [3:0] ra,
    input  word_t [3:0] rb,
    input  word_t [3:0] rc,
    input  word_t [3:0] rd,
    output word_t [3:0] qa,
    output word_t [3:0] qb,
    output word_t [3:0] qc,
    output word_t [3:0] qd,
    output state_t      next_st
);

    always_comb begin
        qa = '0;
        qb = '0;
        qc = '0;
        qd = '0;
        for (int q = 0; q < 4; q++) begin
            qa[q] = work_st[diag ? DIAG_IDX[q][0] : COL_IDX[q][0]];
            qb[q] = work_st[diag ? DIAG_IDX[q][1] : COL_IDX[q][1]];
            qc[q] = work_st[diag ? DIAG_IDX[q][2] : COL_IDX[q][2]];
            qd[q] = work_st[diag ? DIAG_IDX[q][3] : COL_IDX[q][3]];
        end
    end

    // Every word belongs to exactly one group, so the default copy is fully overwritten.
    always_comb begin
        next_st = work_st;
        for (int q = 0; q < 4; q++) begin
            next_st[diag ? DIAG_IDX[q][0] : COL_IDX[q][0]] = ra[q];
            next_st[diag ? DIAG_IDX[q][1] : COL_IDX[q][1]] = rb[q];
            next_st[diag ? DIAG_IDX[q][2] : COL_IDX[q][2]] = rc[q];
            next_st[diag ? DIAG_IDX[q][3] : COL_IDX[q][3]] = rd[q];
        end
    end

endmodule

// File: rtl/chacha20_block_ctrl.sv
// Iterative ChaCha20 block function: one round per cycle through four quarter-rounds,
// feed-forward add, and a valid/ready keystream output.
module chacha20_block_ctrl
    import chacha20_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int CNT_W  = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    fsm_t             state, next_state;
    state_t           init_st, work_st, round_st, start_st;
    logic [CNT_W-1:0] rnd;
    logic             accept, last_rnd;
    word_t [3:0]      qa, qb, qc, qd, ra, rb, rc, rd;

    assign start_st = init_state(key, nonce, counter);
    assign accept   = in_valid && in_ready;
    assign last_rnd = (rnd == CNT_W'(ROUNDS - 1));

    chacha20_round_sel u_round_sel (
        .work_st (work_st),
        .diag    (rnd[0]),
        .ra      (ra),
        .rb      (rb),
        .rc      (rc),
        .rd      (rd),
        .qa      (qa),
        .qb      (qb),
        .qc      (qc),
        .qd      (qd),
        .next_st (round_st)
    );

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha20_qr u_qr (
            .a  (qa[g]),
            .b  (qb[g]),
            .c  (qc[g]),
            .d  (qd[g]),
            .na (ra[g]),
            .nb (rb[g]),
            .nc (rc[g]),
            .nd (rd[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ROUND;
            ROUND:   if (last_rnd) next_state = FINAL;
            FINAL:   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // Keystream is written only in FINAL, so it holds steady through DONE backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_st   <= '0;
            work_st   <= '0;
            rnd       <= '0;
            keystream <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        init_st <= start_st;
                        work_st <= start_st;
                        rnd     <= '0;
                    end
                end
                ROUND: begin
                    work_st <= round_st;
                    rnd     <= rnd + 1'b1;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++)
                        keystream[32*i +: 32] <= work_st[i] + init_st[i];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha20_block_ctrl.sv
// Self-checking bench: table of vectors (RFC, zero-key, counter edge, ChaCha8, random)
// against an in-bench ChaCha reference, plus backpressure and mid-block reset sequences.
module tb_chacha20_block_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_valid8, out_ready, out_ready8;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         in_ready, out_valid, busy;
    logic         in_ready8, out_valid8, busy8;
    logic [511:0] keystream, keystream8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    chacha20_block_ctrl #(.ROUNDS(20), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .nonce(nonce), .counter(counter), .out_valid(out_valid),
        .out_ready(out_ready), .keystream(keystream), .busy(busy)
    );

    chacha20_block_ctrl #(.ROUNDS(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .key(key), .nonce(nonce), .counter(counter), .out_valid(out_valid8),
        .out_ready(out_ready8), .keystream(keystream8), .busy(busy8)
    );

    typedef struct {
        logic [255:0] k;
        logic [95:0]  n;
        logic [31:0]  c;
        int           rounds;
        logic [511:0] exp;
        logic [15:0]  wmask;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference block function: straight from the algorithm description, double rounds at a time.
    function automatic logic [511:0] refBlock(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c, input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [31:0] a, b, cc, d;
        int q [8][4];
        logic [511:0] r;
        q = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
              '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int dr = 0; dr < rounds / 2; dr++) begin
            for (int j = 0; j < 8; j++) begin
                a = x[q[j][0]]; b = x[q[j][1]]; cc = x[q[j][2]]; d = x[q[j][3]];
                a = a + b;   d = rotl32(d ^ a, 16);
                cc = cc + d; b = rotl32(b ^ cc, 12);
                a = a + b;   d = rotl32(d ^ a, 8);
                cc = cc + d; b = rotl32(b ^ cc, 7);
                x[q[j][0]] = a; x[q[j][1]] = b; x[q[j][2]] = cc; x[q[j][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    function automatic logic [511:0] wordMask(input logic [15:0] m);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = m[i] ? 32'hffffffff : 32'h0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Accepts one request on the chosen DUT and counts edges from accept to visible out_valid.
    task automatic applyStimulus(input bit u8, input logic [255:0] k, input logic [95:0] n,
                                 input logic [31:0] c, output logic [511:0] ks, output int lat);
        int g = 0;
        @(negedge clk);
        while (!(u8 ? in_ready8 : in_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        key = k; nonce = n; counter = c;
        if (u8) in_valid8 = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0; in_valid8 = 1'b0;
        key = ~k; nonce = ~n; counter = ~c;
        while (!(u8 ? out_valid8 : out_valid) && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ks = u8 ? keystream8 : keystream;
    endtask

    task automatic releaseOut(input bit u8);
        if (u8) out_ready8 = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0; out_ready8 = 1'b0;
        checkOutput("out_valid cleared after handshake", u8 ? out_valid8 : out_valid, 0);
        checkOutput("in_ready back after handshake", u8 ? in_ready8 : in_ready, 1);
    endtask

    initial begin
        logic [255:0] rfc_key, k2;
        logic [95:0]  rfc_nonce;
        logic [511:0] rfc_exp, ks;
        int           lat, bad, g;
        vec_t         v;

        rst_n = 1'b0;
        in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0; out_ready8 = 1'b0;
        key = '0; nonce = '0; counter = '0;

        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        rfc_exp = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
                   32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
                   32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
                   32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

        v = '{rfc_key, rfc_nonce, 32'd1, 20, rfc_exp, 16'hffff};
        vecs.push_back(v);
        v = '{'0, '0, 32'd0, 20, {448'h0, 32'h903df1a0, 32'hade0b876}, 16'h0003};
        vecs.push_back(v);
        v = '{'0, '0, 32'd1, 20, {480'h0, 32'hbee7079f}, 16'h0001};
        vecs.push_back(v);
        v = '{rfc_key, rfc_nonce, 32'hffffffff, 20, refBlock(rfc_key, rfc_nonce, 32'hffffffff, 20), 16'hffff};
        vecs.push_back(v);
        v = '{rfc_key, rfc_nonce, 32'd1, 8, refBlock(rfc_key, rfc_nonce, 32'd1, 8), 16'hffff};
        vecs.push_back(v);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) v.k[32*i +: 32] = $urandom;
            v.n = {$urandom, $urandom, $urandom};
            v.c = $urandom;
            v.rounds = (r == 2) ? 8 : 20;
            v.exp = refBlock(v.k, v.n, v.c, v.rounds);
            v.wmask = 16'hffff;
            vecs.push_back(v);
        end

        #2;
        checkOutput("reset in_ready", {in_ready, in_ready8}, 2'b11);
        checkOutput("reset out_valid", {out_valid, out_valid8}, 2'b00);
        checkOutput("reset busy", {busy, busy8}, 2'b00);
        checkOutput("reset keystream", keystream | keystream8, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rounds == 8, vecs[i].k, vecs[i].n, vecs[i].c, ks, lat);
            checkOutput($sformatf("vec%0d keystream", i), ks & wordMask(vecs[i].wmask),
                        vecs[i].exp & wordMask(vecs[i].wmask));
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].rounds + 1);
            releaseOut(vecs[i].rounds == 8);
        end

        // Backpressure with a competing request held on in_valid.
        applyStimulus(1'b0, rfc_key, rfc_nonce, 32'd1, ks, lat);
        checkOutput("bp keystream", ks, rfc_exp);
        for (int i = 0; i < 8; i++) k2[32*i +: 32] = $urandom;
        key = k2; nonce = rfc_nonce; counter = 32'd5; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (keystream !== rfc_exp || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) bad++;
        end
        checkOutput("bp hold violations", bad, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp release state", {out_valid, in_ready, busy}, 3'b010);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp queued accept", {in_ready, busy}, 2'b01);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("bp second latency", lat, 21);
        checkOutput("bp second keystream", keystream, refBlock(k2, rfc_nonce, 32'd5, 20));
        releaseOut(1'b0);

        // Asynchronous reset after seven rounds.
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        key = rfc_key; nonce = rfc_nonce; counter = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset state", {busy, in_ready, out_valid}, 3'b010);
        checkOutput("async reset keystream", keystream, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checkOutput("no out_valid after reset", bad, 0);
        applyStimulus(1'b0, rfc_key, rfc_nonce, 32'd1, ks, lat);
        checkOutput("rfc after reset", ks, rfc_exp);
        checkOutput("rfc after reset latency", lat, 21);
        releaseOut(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
